vga_mem_arbiter: RTL and testbench
==================================

# vga_mem_arbiter

Single-port memory arbiter between the monochrome VGA text controller's bus master and the CPU data bus. The VGA fetch path gets fixed priority and deterministic one-cycle read timing. CPU accesses use the spare cycles through a cs/ack handshake. The block drives the shared synchronous 16-bit RAM that holds the font (0x000–0x7FF) and the screen buffer (0x800+). It also flags VGA protocol violations and CPU starvation.

## Interface
Parameters:
- AW, 12, word address width of the shared RAM
- MAX_WAIT, 8'd32, CPU wait cycles that set the timeout flag

Ports:
- i_clk  in  1  system clock; all logic on the rising edge
- i_reset_n  in  1  reset, **asynchronous, active-low**
- i_vga_addr  in  AW  VGA word address
- i_vga_cs  in  1  VGA read strobe, one cycle per access
- i_vga_access  in  1  VGA will assert cs in the next cycle
- o_vga_dat  out  16  read data to VGA
- i_cpu_addr  in  AW  CPU word address
- i_cpu_dat  in  16  CPU write data
- i_cpu_cs  in  1  CPU request; held until ack
- i_cpu_we  in  1  CPU write enable; qualified by cs
- o_cpu_dat  out  16  registered CPU read data
- o_cpu_ack  out  1  one-cycle transaction-complete pulse
- o_mem_addr  out  AW  RAM address
- o_mem_dat  out  16  RAM write data
- o_mem_cs  out  1  RAM enable
- o_mem_we  out  1  RAM write enable
- i_mem_dat  in  16  RAM read data, valid one cycle after o_mem_cs
- o_err_protocol  out  1  sticky: VGA cs without access in the previous cycle
- o_err_timeout  out  1  sticky: CPU waited MAX_WAIT cycles
- o_max_wait  out  8  largest CPU wait observed, saturating

## Operation
FSM states and transitions:
- **IDLE**
  - Let grant = i_cpu_cs & ~i_vga_cs & ~i_vga_access.
  - If grant is high: the RAM port carries the CPU request this cycle, and the FSM moves to CAPTURE.
  - Otherwise the FSM stays in IDLE.
- **CAPTURE**
  - On a read, i_mem_dat is registered into o_cpu_dat.
  - On a write, o_cpu_dat holds its value.
  - Moves to ACK.
- **ACK**
  - o_cpu_ack is high for exactly this cycle.
  - Moves to IDLE.
  - Grant is not evaluated in ACK.

RAM port mux (combinational):
- **VGA cs high:** o_mem_addr=i_vga_addr, o_mem_cs=1, o_mem_we=0.
- **Otherwise, grant high:** o_mem_addr=i_cpu_addr, o_mem_dat=i_cpu_dat, o_mem_cs=1, o_mem_we=i_cpu_we.
- **Otherwise:** o_mem_cs=0, o_mem_we=0.
- **While i_reset_n is low:** o_mem_cs=0 and o_mem_we=0, regardless of the above.

Other behaviour:
- o_vga_dat = i_mem_dat, combinational. VGA samples it in the cycle after its cs.
- VGA never waits. CPU is never granted in the cycle that carries a VGA cs, nor in the cycle that carries VGA access (which precedes a VGA cs).
- CPU must hold addr, dat and we stable from cs rising until the ack cycle.
  - If cs stays high after ack, the arbiter treats it as a new request.
  - If cs drops before grant, the request is abandoned and no ack is issued.
- Wait counter (8-bit, saturating at 255):
  - Increments each cycle in IDLE with i_cpu_cs high and grant low.
  - Clears on grant or when cs is low.
  - o_max_wait <= max(o_max_wait, counter).
  - o_err_timeout sets when counter == MAX_WAIT.
- Protocol check: an access_d register holds i_vga_access from the previous cycle. If i_vga_cs is high and access_d is low, o_err_protocol sets one cycle later.
- Both error flags clear only on reset.

## Timing
- Reset values: state=IDLE, o_cpu_ack=0, o_cpu_dat=0, access_d=0, wait counter=0, o_max_wait=0, both error flags=0.
- CPU latency from grant cycle t:
  - RAM accessed at t.
  - Data captured at the end of t+1.
  - Ack at t+2.
  - Earliest next grant at t+3.
- CPU latency from cs rise with VGA idle: ack 2 cycles later.
- VGA latency: the address is on the RAM in the same cycle as cs; data is on o_vga_dat the next cycle.
- Reset asserted mid-transaction:
  - State returns to IDLE immediately and no ack is issued.
  - An in-flight write at the RAM is not guaranteed.
  - After release, a held cs is re-arbitrated.
- i_cpu_cs and i_vga_access both high: CPU waits and the wait counter increments.

## Test plan
- **CPU read, VGA idle:** RAM[0x123]=0xBEEF; cs high from cycle 0 with we=0 and addr 0x123 → o_mem_cs=1 and o_mem_addr=0x123 at cycle 0; o_cpu_ack=1 and o_cpu_dat=0xBEEF at cycle 2 only.
- **CPU write vs VGA:** access at c0, VGA cs at c1 (addr 0x801); CPU write 0x5A5A to 0x900 from c0 → RAM gets VGA at c1 and the CPU write (we=1) at c2; o_vga_dat=RAM[0x801] at c2; ack at c4.
- **Back-to-back CPU:** cs held high for 9 cycles with VGA idle → grants at 0, 3, 6; acks at 2, 5, 8.
- **Protocol violation:** VGA cs with no access in the preceding cycle → o_err_protocol=1 the next cycle; it stays 1 until i_reset_n is pulsed low.
- **Starvation:** MAX_WAIT=4; i_vga_access high for 6 cycles while cs is high → o_err_timeout=1; after the grant, o_max_wait=6.
- **Async reset mid-read:** i_reset_n low in CAPTURE → o_cpu_ack stays 0 and o_cpu_dat=0; o_mem_cs=0 while reset is low.

Source files
------------

// File: rtl/vga_mem_arbiter_if.sv
// Shared-RAM bus bundle between the VGA fetch path, the CPU data bus and the RAM.
// The slave modport is the arbiter's view; master is the environment's view.
interface vga_mem_arbiter_if #(
    parameter int AW = 12
);
    logic [AW-1:0] i_vga_addr;
    logic          i_vga_cs;
    logic          i_vga_access;
    logic [15:0]   o_vga_dat;
    logic [AW-1:0] i_cpu_addr;
    logic [15:0]   i_cpu_dat;
    logic          i_cpu_cs;
    logic          i_cpu_we;
    logic [15:0]   o_cpu_dat;
    logic          o_cpu_ack;
    logic [AW-1:0] o_mem_addr;
    logic [15:0]   o_mem_dat;
    logic          o_mem_cs;
    logic          o_mem_we;
    logic [15:0]   i_mem_dat;
    logic          o_err_protocol;
    logic          o_err_timeout;
    logic [7:0]    o_max_wait;

    modport slave (
        input  i_vga_addr, i_vga_cs, i_vga_access,
        input  i_cpu_addr, i_cpu_dat, i_cpu_cs, i_cpu_we,
        input  i_mem_dat,
        output o_vga_dat, o_cpu_dat, o_cpu_ack,
        output o_mem_addr, o_mem_dat, o_mem_cs, o_mem_we,
        output o_err_protocol, o_err_timeout, o_max_wait
    );

    modport master (
        output i_vga_addr, i_vga_cs, i_vga_access,
        output i_cpu_addr, i_cpu_dat, i_cpu_cs, i_cpu_we,
        output i_mem_dat,
        input  o_vga_dat, o_cpu_dat, o_cpu_ack,
        input  o_mem_addr, o_mem_dat, o_mem_cs, o_mem_we,
        input  o_err_protocol, o_err_timeout, o_max_wait
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Single-port RAM arbiter: VGA reads have fixed priority and one-cycle timing,
// the CPU fills the spare cycles through a cs/ack handshake.
module vga_mem_arbiter #(
    parameter int          AW       = 12,
    parameter logic [7:0]  MAX_WAIT = 8'd32
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    vga_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CAPTURE, ACK} state_t;

    state_t     state, state_nxt;
    logic       grant;
    logic       we_q;
    logic       access_d;
    logic [7:0] wait_cnt;

    // CPU only gets the port when VGA neither uses it now nor announced it for next cycle.
    assign grant = (state == IDLE) & bus.i_cpu_cs & ~bus.i_vga_cs & ~bus.i_vga_access;

    assign bus.o_vga_dat = bus.i_mem_dat;
    assign bus.o_cpu_ack = (state == ACK);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = CAPTURE;
            CAPTURE: state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM port mux; enables are forced off while reset is held.
    always_comb begin
        bus.o_mem_addr = bus.i_vga_addr;
        bus.o_mem_dat  = bus.i_cpu_dat;
        bus.o_mem_cs   = 1'b0;
        bus.o_mem_we   = 1'b0;
        if (bus.i_vga_cs) begin
            bus.o_mem_cs = 1'b1;
        end else if (grant) begin
            bus.o_mem_addr = bus.i_cpu_addr;
            bus.o_mem_cs   = 1'b1;
            bus.o_mem_we   = bus.i_cpu_we;
        end
        if (!i_reset_n) begin
            bus.o_mem_cs = 1'b0;
            bus.o_mem_we = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus.o_cpu_dat <= '0;
            we_q          <= 1'b0;
        end else begin
            if (grant) we_q <= bus.i_cpu_we;
            if (state == CAPTURE && !we_q) bus.o_cpu_dat <= bus.i_mem_dat;
        end
    end

    // Starvation monitor: counter only advances while a request is blocked in IDLE.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wait_cnt          <= '0;
            bus.o_max_wait    <= '0;
            bus.o_err_timeout <= 1'b0;
        end else begin
            if (grant || !bus.i_cpu_cs)                      wait_cnt <= '0;
            else if (state == IDLE && wait_cnt != 8'hFF)    wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt > bus.o_max_wait) bus.o_max_wait <= wait_cnt;
            if (wait_cnt == MAX_WAIT)      bus.o_err_timeout <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            access_d           <= 1'b0;
            bus.o_err_protocol <= 1'b0;
        end else begin
            access_d <= bus.i_vga_access;
            if (bus.i_vga_cs && !access_d) bus.o_err_protocol <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a behavioural synchronous RAM.
module tb_vga_mem_arbiter;
    logic i_clk = 1'b0;
    logic i_reset_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] ram [0:4095];

    vga_mem_arbiter_if #(.AW(12)) bus();

    vga_mem_arbiter #(.AW(12), .MAX_WAIT(8'd4)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (bus.o_mem_cs) begin
            if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_dat;
            else              bus.i_mem_dat <= ram[bus.o_mem_addr];
        end
    end

    task tick;
        @(posedge i_clk);
        #1;
    endtask

    task idle_inputs;
        bus.i_vga_addr = '0; bus.i_vga_cs = 0; bus.i_vga_access = 0;
        bus.i_cpu_addr = '0; bus.i_cpu_dat = '0; bus.i_cpu_cs = 0; bus.i_cpu_we = 0;
    endtask

    task do_reset;
        i_reset_n = 1'b0;
        idle_inputs();
        tick(); tick();
        i_reset_n = 1'b1;
    endtask

    task test_reset;
        idle_inputs();
        #2 i_reset_n = 1'b0;
        bus.i_vga_cs = 1; bus.i_cpu_cs = 1; bus.i_cpu_we = 1;
        tick(); #1;
        checks++; if (bus.o_cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %0h exp 0", bus.o_cpu_ack); end
        checks++; if (bus.o_cpu_dat !== 16'h0) begin errors++; $display("FAIL rst_cpu_dat got %0h exp 0", bus.o_cpu_dat); end
        checks++; if (bus.o_max_wait !== 8'h0) begin errors++; $display("FAIL rst_max_wait got %0h exp 0", bus.o_max_wait); end
        checks++; if (bus.o_err_protocol !== 1'b0) begin errors++; $display("FAIL rst_err_protocol got %0h exp 0", bus.o_err_protocol); end
        checks++; if (bus.o_err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err_timeout got %0h exp 0", bus.o_err_timeout); end
        checks++; if (bus.o_mem_cs !== 1'b0) begin errors++; $display("FAIL rst_mem_cs got %0h exp 0", bus.o_mem_cs); end
        checks++; if (bus.o_mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %0h exp 0", bus.o_mem_we); end
        idle_inputs();
        tick();
        i_reset_n = 1'b1;
    endtask

    task test_cpu_read;
        tick();
        bus.i_cpu_cs = 1; bus.i_cpu_we = 0; bus.i_cpu_addr = 12'h123;
        #1;
        checks++; if (bus.o_mem_cs !== 1'b1) begin errors++; $display("FAIL rd_mem_cs_c0 got %0h exp 1", bus.o_mem_cs); end
        checks++; if (bus.o_mem_addr !== 12'h123) begin errors++; $display("FAIL rd_mem_addr_c0 got %0h exp 123", bus.o_mem_addr); end
        checks++; if (bus.o_cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_c0 got %0h exp 0", bus.o_cpu_ack); end
        tick(); #1;
        checks++; if (bus.o_cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_c1 got %0h exp 0", bus.o_cpu_ack); end
        tick(); #1;
        checks++; if (bus.o_cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_ack_c2 got %0h exp 1", bus.o_cpu_ack); end
        checks++; if (bus.o_cpu_dat !== 16'hBEEF) begin errors++; $display("FAIL rd_dat_c2 got %0h exp beef", bus.o_cpu_dat); end
        tick();
        bus.i_cpu_cs = 0;
        #1;
        checks++; if (bus.o_cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_c3 got %0h exp 0", bus.o_cpu_ack); end
    endtask

    task test_write_vs_vga;
        tick();
        bus.i_vga_access = 1;
        bus.i_cpu_cs = 1; bus.i_cpu_we = 1; bus.i_cpu_addr = 12'h900; bus.i_cpu_dat = 16'h5A5A;
        #1;
        checks++; if (bus.o_mem_cs !== 1'b0) begin errors++; $display("FAIL wr_mem_cs_c0 got %0h exp 0", bus.o_mem_cs); end
        tick();
        bus.i_vga_access = 0; bus.i_vga_cs = 1; bus.i_vga_addr = 12'h801;
        #1;
        checks++; if (bus.o_mem_addr !== 12'h801) begin errors++; $display("FAIL wr_vga_addr_c1 got %0h exp 801", bus.o_mem_addr); end
        checks++; if (bus.o_mem_we !== 1'b0) begin errors++; $display("FAIL wr_vga_we_c1 got %0h exp 0", bus.o_mem_we); end
        tick();
        bus.i_vga_cs = 0;
        #1;
        checks++; if (bus.o_mem_cs !== 1'b1) begin errors++; $display("FAIL wr_mem_cs_c2 got %0h exp 1", bus.o_mem_cs); end
        checks++; if (bus.o_mem_addr !== 12'h900) begin errors++; $display("FAIL wr_mem_addr_c2 got %0h exp 900", bus.o_mem_addr); end
        checks++; if (bus.o_mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we_c2 got %0h exp 1", bus.o_mem_we); end
        checks++; if (bus.o_mem_dat !== 16'h5A5A) begin errors++; $display("FAIL wr_mem_dat_c2 got %0h exp 5a5a", bus.o_mem_dat); end
        checks++; if (bus.o_vga_dat !== 16'h1234) begin errors++; $display("FAIL wr_vga_dat_c2 got %0h exp 1234", bus.o_vga_dat); end
        tick(); #1;
        checks++; if (bus.o_cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_c3 got %0h exp 0", bus.o_cpu_ack); end
        tick(); #1;
        checks++; if (bus.o_cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack_c4 got %0h exp 1", bus.o_cpu_ack); end
        tick();
        bus.i_cpu_cs = 0; bus.i_cpu_we = 0;
        #1;
        checks++; if (ram[12'h900] !== 16'h5A5A) begin errors++; $display("FAIL wr_ram_900 got %0h exp 5a5a", ram[12'h900]); end
        checks++; if (bus.o_err_protocol !== 1'b0) begin errors++; $display("FAIL wr_no_protocol got %0h exp 0", bus.o_err_protocol); end
    endtask

    task test_back_to_back;
        for (int c = 0; c < 9; c++) begin
            tick();
            if (c == 0) begin bus.i_cpu_cs = 1; bus.i_cpu_we = 0; bus.i_cpu_addr = 12'h123; end
            #1;
            checks++; if (bus.o_mem_cs !== (c % 3 == 0)) begin errors++; $display("FAIL b2b_mem_cs_c%0d got %0h exp %0h", c, bus.o_mem_cs, (c % 3 == 0)); end
            checks++; if (bus.o_cpu_ack !== (c % 3 == 2)) begin errors++; $display("FAIL b2b_ack_c%0d got %0h exp %0h", c, bus.o_cpu_ack, (c % 3 == 2)); end
        end
        tick();
        bus.i_cpu_cs = 0;
    endtask

    task test_protocol;
        tick();
        bus.i_vga_cs = 1; bus.i_vga_addr = 12'h800;
        #1;
        checks++; if (bus.o_err_protocol !== 1'b0) begin errors++; $display("FAIL prot_c0 got %0h exp 0", bus.o_err_protocol); end
        tick();
        bus.i_vga_cs = 0;
        #1;
        checks++; if (bus.o_err_protocol !== 1'b1) begin errors++; $display("FAIL prot_c1 got %0h exp 1", bus.o_err_protocol); end
        tick(); tick(); #1;
        checks++; if (bus.o_err_protocol !== 1'b1) begin errors++; $display("FAIL prot_sticky got %0h exp 1", bus.o_err_protocol); end
        do_reset();
        #1;
        checks++; if (bus.o_err_protocol !== 1'b0) begin errors++; $display("FAIL prot_cleared got %0h exp 0", bus.o_err_protocol); end
    endtask

    task test_starvation;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                bus.i_vga_access = 1; bus.i_cpu_cs = 1; bus.i_cpu_we = 0; bus.i_cpu_addr = 12'h123;
            end
            #1;
            checks++; if (bus.o_mem_cs !== 1'b0) begin errors++; $display("FAIL starve_mem_cs_c%0d got %0h exp 0", k, bus.o_mem_cs); end
            if (k == 4) begin
                checks++; if (bus.o_err_timeout !== 1'b0) begin errors++; $display("FAIL starve_tmo_c4 got %0h exp 0", bus.o_err_timeout); end
            end
            if (k == 5) begin
                checks++; if (bus.o_err_timeout !== 1'b1) begin errors++; $display("FAIL starve_tmo_c5 got %0h exp 1", bus.o_err_timeout); end
            end
        end
        tick();
        bus.i_vga_access = 0;
        #1;
        checks++; if (bus.o_mem_cs !== 1'b1) begin errors++; $display("FAIL starve_grant got %0h exp 1", bus.o_mem_cs); end
        checks++; if (bus.o_max_wait !== 8'd5) begin errors++; $display("FAIL starve_max_c6 got %0d exp 5", bus.o_max_wait); end
        tick(); #1;
        checks++; if (bus.o_max_wait !== 8'd6) begin errors++; $display("FAIL starve_max_c7 got %0d exp 6", bus.o_max_wait); end
        tick(); #1;
        checks++; if (bus.o_cpu_ack !== 1'b1) begin errors++; $display("FAIL starve_ack got %0h exp 1", bus.o_cpu_ack); end
        tick();
        bus.i_cpu_cs = 0;
        #1;
        checks++; if (bus.o_max_wait !== 8'd6) begin errors++; $display("FAIL starve_max_hold got %0d exp 6", bus.o_max_wait); end
    endtask

    task test_reset_mid_read;
        tick();
        bus.i_cpu_cs = 1; bus.i_cpu_we = 0; bus.i_cpu_addr = 12'h123;
        #1;
        checks++; if (bus.o_mem_cs !== 1'b1) begin errors++; $display("FAIL mid_grant got %0h exp 1", bus.o_mem_cs); end
        tick();
        i_reset_n = 1'b0;
        #1;
        checks++; if (bus.o_mem_cs !== 1'b0) begin errors++; $display("FAIL mid_mem_cs got %0h exp 0", bus.o_mem_cs); end
        checks++; if (bus.o_cpu_dat !== 16'h0) begin errors++; $display("FAIL mid_cpu_dat got %0h exp 0", bus.o_cpu_dat); end
        checks++; if (bus.o_cpu_ack !== 1'b0) begin errors++; $display("FAIL mid_ack_c1 got %0h exp 0", bus.o_cpu_ack); end
        tick(); #1;
        checks++; if (bus.o_cpu_ack !== 1'b0) begin errors++; $display("FAIL mid_ack_c2 got %0h exp 0", bus.o_cpu_ack); end
        checks++; if (bus.o_mem_cs !== 1'b0) begin errors++; $display("FAIL mid_mem_cs_c2 got %0h exp 0", bus.o_mem_cs); end
        checks++; if (bus.o_err_timeout !== 1'b0) begin errors++; $display("FAIL mid_tmo_clr got %0h exp 0", bus.o_err_timeout); end
        checks++; if (bus.o_max_wait !== 8'd0) begin errors++; $display("FAIL mid_max_clr got %0d exp 0", bus.o_max_wait); end
        tick();
        bus.i_cpu_cs = 0;
        i_reset_n = 1'b1;
        #1;
        checks++; if (bus.o_cpu_ack !== 1'b0) begin errors++; $display("FAIL mid_ack_c3 got %0h exp 0", bus.o_cpu_ack); end
        tick(); #1;
        checks++; if (bus.o_cpu_ack !== 1'b0) begin errors++; $display("FAIL mid_ack_c4 got %0h exp 0", bus.o_cpu_ack); end
    endtask

    initial begin
        ram[12'h123] = 16'hBEEF;
        ram[12'h801] = 16'h1234;
        ram[12'h900] = 16'h0000;
        test_reset();
        test_cpu_read();
        test_write_vs_vga();
        test_back_to_back();
        test_protocol();
        test_starvation();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
